// File: rtl/key_repeat_conditioner_pkg.sv
// Shared types and default timing for the key conditioner: per-key FSM states,
// nominal 50 MHz timing values and a counter-sizing helper.
package key_cond_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } key_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYC = 25_000;
  localparam int unsigned DEF_REPEAT_DELAY = 25_000_000;
  localparam int unsigned DEF_REPEAT_SLOW  = 10_000_000;
  localparam int unsigned DEF_REPEAT_FAST  = 1_000_000;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/key_repeat_conditioner_if.sv
// Key-side signal bundle: raw buttons and Accel in, conditioned strobes and levels out.
interface key_repeat_conditioner_if;

  logic Up;
  logic Down;
  logic Accel;
  logic Up_Pulse;
  logic Down_Pulse;
  logic Up_Held;
  logic Down_Held;
  logic Conflict;

  modport master (
    output Up, Down, Accel,
    input  Up_Pulse, Down_Pulse, Up_Held, Down_Held, Conflict
  );

  modport slave (
    input  Up, Down, Accel,
    output Up_Pulse, Down_Pulse, Up_Held, Down_Held, Conflict
  );

endinterface

// File: rtl/key_repeat_conditioner_key_channel.sv
// One push-button channel: 2-FF synchroniser, debounce, and press / auto-repeat FSM.
// The pulse output is combinational; the top registers it together with the level.
module key_channel
  import key_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_SLOW  = DEF_REPEAT_SLOW,
  parameter int unsigned REPEAT_FAST  = DEF_REPEAT_FAST
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  input  logic accel,
  output logic held,
  output logic pulse
);

  localparam int CW = $clog2(max4(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_SLOW, REPEAT_FAST) + 1);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEB_LAST = cnt_t'(DEBOUNCE_CYC - 1);
  localparam cnt_t DELAY_LD = cnt_t'(REPEAT_DELAY);
  localparam cnt_t SLOW_LD  = cnt_t'(REPEAT_SLOW);
  localparam cnt_t FAST_LD  = cnt_t'(REPEAT_FAST);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       held_q, held_d;
  cnt_t       db_cnt_q, db_cnt_d;
  key_state_e state_q, state_d;
  cnt_t       rep_cnt_q, rep_cnt_d;
  logic       key_pressed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      held_q    <= 1'b0;
      db_cnt_q  <= '0;
      state_q   <= IDLE;
      rep_cnt_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      held_q    <= held_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  assign key_pressed = ~sync2_q;

  // A one-bit synced value that matches held has either never moved or just bounced back,
  // so clearing on "matches held" is the same as clearing on any change.
  always_comb begin
    sync1_d  = key_n;
    sync2_d  = sync1_q;
    held_d   = held_q;
    db_cnt_d = '0;
    if (key_pressed != held_q) begin
      if (db_cnt_q == DEB_LAST) begin
        held_d = key_pressed;
      end else begin
        db_cnt_d = db_cnt_q + cnt_t'(1);
      end
    end
  end

  // Counters load the full interval and fire on the cycle the count would reach zero,
  // giving exactly REPEAT_DELAY / period cycles between consecutive pulses.
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    pulse     = 1'b0;
    if (!held_q) begin
      state_d   = IDLE;
      rep_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          pulse     = 1'b1;
          rep_cnt_d = DELAY_LD;
          state_d   = DELAY;
        end
        DELAY, REPEAT: begin
          if (rep_cnt_q == cnt_t'(1)) begin
            pulse     = 1'b1;
            rep_cnt_d = accel ? FAST_LD : SLOW_LD;
            state_d   = REPEAT;
          end else begin
            rep_cnt_d = rep_cnt_q - cnt_t'(1);
          end
        end
        default: begin
          state_d   = IDLE;
          rep_cnt_d = '0;
        end
      endcase
    end
  end

  assign held = held_q;

endmodule

// File: rtl/key_repeat_conditioner.sv
// Up/Down button conditioner for the alarm clock core: two key channels plus
// conflict masking and registered outputs.
module key_repeat_conditioner
  import key_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_SLOW  = DEF_REPEAT_SLOW,
  parameter int unsigned REPEAT_FAST  = DEF_REPEAT_FAST
) (
  input  logic                       Clk_50MHz,
  input  logic                       Rst_n,
  key_repeat_conditioner_if.slave    keys
);

  logic up_held, up_pulse, dn_held, dn_pulse;
  logic up_pulse_q, up_pulse_d;
  logic dn_pulse_q, dn_pulse_d;
  logic up_held_q, up_held_d;
  logic dn_held_q, dn_held_d;
  logic conflict_q, conflict_d;

  key_channel #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_SLOW  (REPEAT_SLOW),
    .REPEAT_FAST  (REPEAT_FAST)
  ) u_up (
    .clk   (Clk_50MHz),
    .rst_n (Rst_n),
    .key_n (keys.Up),
    .accel (keys.Accel),
    .held  (up_held),
    .pulse (up_pulse)
  );

  key_channel #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_SLOW  (REPEAT_SLOW),
    .REPEAT_FAST  (REPEAT_FAST)
  ) u_down (
    .clk   (Clk_50MHz),
    .rst_n (Rst_n),
    .key_n (keys.Down),
    .accel (keys.Accel),
    .held  (dn_held),
    .pulse (dn_pulse)
  );

  // Masked pulses are dropped outright; the channels keep their own schedules.
  always_comb begin
    conflict_d = up_held & dn_held;
    up_held_d  = up_held;
    dn_held_d  = dn_held;
    up_pulse_d = up_pulse & ~conflict_d;
    dn_pulse_d = dn_pulse & ~conflict_d;
  end

  always_ff @(posedge Clk_50MHz or negedge Rst_n) begin
    if (!Rst_n) begin
      up_pulse_q <= 1'b0;
      dn_pulse_q <= 1'b0;
      up_held_q  <= 1'b0;
      dn_held_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      up_pulse_q <= up_pulse_d;
      dn_pulse_q <= dn_pulse_d;
      up_held_q  <= up_held_d;
      dn_held_q  <= dn_held_d;
      conflict_q <= conflict_d;
    end
  end

  assign keys.Up_Pulse   = up_pulse_q;
  assign keys.Down_Pulse = dn_pulse_q;
  assign keys.Up_Held    = up_held_q;
  assign keys.Down_Held  = dn_held_q;
  assign keys.Conflict   = conflict_q;

endmodule

// File: tb/tb_key_repeat_conditioner.sv
// Bench for key_repeat_conditioner: directed scenarios and random key activity checked
// every cycle against a schedule-based reference model.
module tb_key_repeat_conditioner;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RS = 8;
  localparam int RF = 2;

  logic Clk_50MHz = 1'b0;
  logic Rst_n     = 1'b0;

  always #5 Clk_50MHz = ~Clk_50MHz;

  key_repeat_conditioner_if keys();

  key_repeat_conditioner #(
    .DEBOUNCE_CYC (D),
    .REPEAT_DELAY (RD),
    .REPEAT_SLOW  (RS),
    .REPEAT_FAST  (RF)
  ) dut (
    .Clk_50MHz (Clk_50MHz),
    .Rst_n     (Rst_n),
    .keys      (keys)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: key levels sampled at each edge, a run length of edges the synced
  // level has disagreed with the accepted level, and absolute edge numbers for the next pulse.
  int   edge_n;
  logic m_s1   [2];
  logic m_s2   [2];
  logic m_held [2];
  logic m_held_prev [2];
  int   m_run  [2];
  int   m_next [2];
  logic e_pulse [2];
  logic e_held  [2];
  logic e_conf;

  int up_cnt, dn_cnt, conf_cycles, pulse_in_conf;
  int up_times[$];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 1'b1;
      m_s2[i] = 1'b1;
      m_held[i] = 1'b0;
      m_held_prev[i] = 1'b0;
      m_run[i] = 0;
      m_next[i] = -1;
      e_pulse[i] = 1'b0;
      e_held[i] = 1'b0;
    end
    e_conf = 1'b0;
  endfunction

  function automatic void model_edge(input logic up_raw, input logic dn_raw, input logic acc);
    logic raw [2];
    logic fire;
    logic pressed;
    raw[0] = up_raw;
    raw[1] = dn_raw;
    e_conf = m_held[0] & m_held[1];
    for (int i = 0; i < 2; i++) begin
      fire = 1'b0;
      if (m_held[i] && !m_held_prev[i]) begin
        fire = 1'b1;
        m_next[i] = edge_n + RD;
      end else if (m_held[i] && edge_n == m_next[i]) begin
        fire = 1'b1;
        m_next[i] = edge_n + (acc ? RF : RS);
      end
      e_pulse[i] = fire & ~e_conf;
      e_held[i]  = m_held[i];
    end
    for (int i = 0; i < 2; i++) begin
      m_held_prev[i] = m_held[i];
      pressed = ~m_s2[i];
      if (pressed != m_held[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_held[i] = pressed;
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    chk_bit("up_pulse",   keys.Up_Pulse,   e_pulse[0]);
    chk_bit("down_pulse", keys.Down_Pulse, e_pulse[1]);
    chk_bit("up_held",    keys.Up_Held,    e_held[0]);
    chk_bit("down_held",  keys.Down_Held,  e_held[1]);
    chk_bit("conflict",   keys.Conflict,   e_conf);
  endtask

  task automatic applyStimulus(input logic up, input logic dn, input logic acc);
    keys.Up    = up;
    keys.Down  = dn;
    keys.Accel = acc;
    @(posedge Clk_50MHz);
    edge_n++;
    if (Rst_n) model_edge(up, dn, acc);
    #1;
    checkOutput();
    if (keys.Up_Pulse) begin
      up_cnt++;
      up_times.push_back(edge_n);
    end
    if (keys.Down_Pulse) dn_cnt++;
    if (keys.Conflict) begin
      conf_cycles++;
      if (keys.Up_Pulse || keys.Down_Pulse) pulse_in_conf++;
    end
  endtask

  task automatic clear_counts();
    up_cnt = 0;
    dn_cnt = 0;
    conf_cycles = 0;
    pulse_in_conf = 0;
    up_times.delete();
  endtask

  initial begin
    int first_at;
    int seg_len;
    logic r_up, r_dn, r_acc;

    edge_n = 0;
    model_reset();
    clear_counts();
    keys.Up = 1'b1;
    keys.Down = 1'b1;
    keys.Accel = 1'b0;
    repeat (3) @(posedge Clk_50MHz);
    #1;
    checkOutput();
    #2;
    Rst_n = 1'b1;
    repeat (5) applyStimulus(1, 1, 0);

    // Scenario 1: clean 10-cycle Up press, single pulse on the 7th edge (T+6)
    $display("[TB] clean press");
    clear_counts();
    first_at = 0;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0, 1, 0);
      if (keys.Up_Pulse && first_at == 0) first_at = i;
    end
    repeat (20) applyStimulus(1, 1, 0);
    chk_int("t1_first_pulse_edge", first_at, D + 3);
    chk_int("t1_up_pulses", up_cnt, 1);
    chk_int("t1_down_pulses", dn_cnt, 0);

    // Scenario 2: bounce every 2 cycles, then steady low
    $display("[TB] bounce");
    clear_counts();
    for (int i = 0; i < 12; i++) applyStimulus(((i / 2) % 2) == 1, 1, 0);
    chk_int("t2_pulses_during_bounce", up_cnt, 0);
    first_at = 0;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(0, 1, 0);
      if (keys.Up_Pulse && first_at == 0) first_at = i;
    end
    repeat (20) applyStimulus(1, 1, 0);
    chk_int("t2_first_pulse_edge", first_at, D + 3);
    chk_int("t2_up_pulses", up_cnt, 1);

    // Scenario 3: Down held 60 cycles, slow repeat: offsets 0,20,28,36,44,52
    $display("[TB] down hold slow repeat");
    clear_counts();
    repeat (60) applyStimulus(1, 0, 0);
    repeat (30) applyStimulus(1, 1, 0);
    chk_int("t3_down_pulses", dn_cnt, 6);
    chk_int("t3_up_pulses", up_cnt, 0);

    // Scenario 4: Accel rises inside the first REPEAT period
    $display("[TB] accel change");
    clear_counts();
    for (int i = 1; i <= 50; i++) applyStimulus(0, 1, (i >= 31));
    repeat (20) applyStimulus(1, 1, 0);
    chk_int("t4_pulse_count_ge4", (up_times.size() >= 4) ? 1 : 0, 1);
    if (up_times.size() >= 4) begin
      chk_int("t4_delay_gap", up_times[1] - up_times[0], RD);
      chk_int("t4_slow_gap",  up_times[2] - up_times[1], RS);
      chk_int("t4_fast_gap",  up_times[3] - up_times[2], RF);
    end

    // Scenario 5: Down joins a held Up after 30 cycles
    $display("[TB] conflict");
    clear_counts();
    repeat (30) applyStimulus(0, 1, 0);
    repeat (20) applyStimulus(0, 0, 0);
    repeat (40) applyStimulus(0, 1, 0);
    repeat (20) applyStimulus(1, 1, 0);
    chk_int("t5_conflict_seen", (conf_cycles > 0) ? 1 : 0, 1);
    chk_int("t5_pulses_in_conflict", pulse_in_conf, 0);
    chk_int("t5_down_pulses", dn_cnt, 0);

    // Scenario 6: asynchronous reset mid-REPEAT with Up still held
    $display("[TB] reset mid-hold");
    clear_counts();
    repeat (31) applyStimulus(0, 1, 0);
    #3;
    Rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput();
    repeat (3) applyStimulus(0, 1, 0);
    #2;
    Rst_n = 1'b1;
    first_at = 0;
    for (int i = 1; i <= 20 && first_at == 0; i++) begin
      applyStimulus(0, 1, 0);
      if (keys.Up_Pulse) first_at = i;
    end
    chk_int("t6_first_pulse_after_reset", first_at, D + 3);
    repeat (20) applyStimulus(1, 1, 0);

    // Random segments of key levels and Accel; short segments act as bounces
    $display("[TB] random");
    for (int s = 0; s < 60; s++) begin
      r_up    = ($urandom_range(0, 2) != 0);
      r_dn    = ($urandom_range(0, 3) != 0);
      r_acc   = $urandom_range(0, 1);
      seg_len = $urandom_range(1, 40);
      repeat (seg_len) applyStimulus(r_up, r_dn, r_acc);
    end
    repeat (20) applyStimulus(1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
